// File: rtl/odo_sbox_inv_loader.sv
// Inverse S-box loader: learns a forward W-bit S-box one entry at a time, checks
// that it is a permutation, and then serves registered inverse lookups.
module odo_sbox_inv_loader #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         wr_en,
  input  logic [W-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         in_valid,
  input  logic [W-1:0] in,
  output logic [W-1:0] out,
  output logic         out_valid,
  output logic         ready,
  output logic         error
);

  localparam int unsigned DEPTH = 2**W;
  localparam int unsigned CNT_W = W + 1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_READY,
    ST_ERROR
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_addr_seen;
  logic [DEPTH-1:0] r_data_seen;
  logic [W-1:0]     r_inv [DEPTH];

  logic w_wr_acc;
  logic w_dup;
  logic w_wr_ok;
  logic w_last;
  logic w_lookup;

  // clear outranks both write and lookup strobes on the same edge
  always_comb begin
    w_wr_acc = wr_en && (r_state == ST_LOAD) && !clear;
    w_dup    = r_addr_seen[wr_addr] | r_data_seen[wr_data];
    w_wr_ok  = w_wr_acc && !w_dup;
    w_last   = (r_count == CNT_W'(DEPTH - 1));
    w_lookup = in_valid && (r_state == ST_READY) && !clear;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_LOAD;
    end else begin
      unique case (r_state)
        ST_LOAD: begin
          if (w_wr_acc && w_dup)       w_state_nxt = ST_ERROR;
          else if (w_wr_ok && w_last)  w_state_nxt = ST_READY;
        end
        ST_READY: w_state_nxt = ST_READY;
        ST_ERROR: w_state_nxt = ST_ERROR;
        default:  w_state_nxt = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LOAD;
      r_count     <= '0;
      r_addr_seen <= '0;
      r_data_seen <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (clear) begin
        r_count     <= '0;
        r_addr_seen <= '0;
        r_data_seen <= '0;
      end else if (w_wr_ok) begin
        r_count              <= r_count + 1'b1;
        r_addr_seen[wr_addr] <= 1'b1;
        r_data_seen[wr_data] <= 1'b1;
      end
    end
  end

  // Table storage carries no reset so it maps onto a plain synchronous RAM
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_inv[wr_data] <= wr_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= w_lookup;
      if (w_lookup) begin
        out <= r_inv[in];
      end
    end
  end

  always_comb begin
    ready = (r_state == ST_READY);
    error = (r_state == ST_ERROR);
  end

endmodule

// File: tb/tb_odo_sbox_inv_loader.sv
// Bench for odo_sbox_inv_loader: directed loads/lookups, expected inverses queued
// by the stimulus and consumed by an independent output monitor.
module tb_odo_sbox_inv_loader;

  localparam int unsigned W = 6;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         clear    = 1'b0;
  logic         wr_en    = 1'b0;
  logic [W-1:0] wr_addr  = '0;
  logic [W-1:0] wr_data  = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in       = '0;
  logic [W-1:0] out;
  logic         out_valid;
  logic         ready;
  logic         error;

  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] mon_exp;

  always #5 clk = ~clk;

  odo_sbox_inv_loader #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .in_valid (in_valid),
    .in       (in),
    .out      (out),
    .out_valid(out_valid),
    .ready    (ready),
    .error    (error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid: got out=0x%0h, expected no result (t=%0t)", out, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("lookup_out", 32'(out), 32'(mon_exp));
      end
    end
  end

  // S(x) = 5x + 0x2d mod 64; hand-derived inverse is 13(y - 0x2d) mod 64
  function automatic logic [W-1:0] perm(input logic [W-1:0] x);
    int unsigned t;
    t = int'(x);
    return W'((t * 5 + 45) % 64);
  endfunction

  task automatic wr(input logic [W-1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic look(input logic [W-1:0] y, input bit expect_out, input logic [W-1:0] e);
    in_valid = 1'b1; in = y;
    if (expect_out) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic load_full(input bit ident, input string tag);
    for (int unsigned x = 0; x < 63; x++)
      wr(W'(x), ident ? W'(x) : perm(W'(x)));
    check({tag, "_ready_before_last"}, 32'(ready), 32'd0);
    wr(6'd63, ident ? 6'd63 : perm(6'd63));
    check({tag, "_ready_after_last"}, 32'(ready), 32'd1);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  // Called at posedge+1: drops rst_n mid-cycle and checks outputs before any edge
  task automatic async_reset(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    check({tag, "_out"}, 32'(out), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Identity load; lookup with 63 entries must be ignored
    for (int unsigned x = 0; x < 63; x++) wr(W'(x), W'(x));
    look(6'h10, 1'b0, '0);
    check("load63_ready", 32'(ready), 32'd0);
    check("load63_out_valid", 32'(out_valid), 32'd0);
    wr(6'd63, 6'd63);
    check("ident_ready", 32'(ready), 32'd1);
    look(6'h2a, 1'b1, 6'h2a);
    check("ident_out_valid", 32'(out_valid), 32'd1);
    idle(1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_out_hold", 32'(out), 32'h2a);

    // Lookup before clear completes; clear edge kills write and lookup
    look(6'h11, 1'b1, 6'h11);
    clear = 1'b1; wr_en = 1'b1; wr_addr = 6'h00; wr_data = 6'h05;
    in_valid = 1'b1; in = 6'h22;
    @(posedge clk); #1;
    clear = 1'b0; wr_en = 1'b0; in_valid = 1'b0;
    check("clr_ready", 32'(ready), 32'd0);
    check("clr_error", 32'(error), 32'd0);
    check("clr_out_valid", 32'(out_valid), 32'd0);

    load_full(1'b0, "perm");
    look(6'h2d, 1'b1, 6'h00);
    look(6'h00, 1'b1, 6'h37);
    look(6'h3f, 1'b1, 6'h2a);
    idle(1);
    check("b2b_done_out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-load
    do_clear();
    for (int unsigned x = 0; x < 40; x++) wr(W'(x), perm(W'(x)));
    async_reset("rst_midload");
    load_full(1'b1, "reload1");

    // Asynchronous reset while out_valid is high
    in_valid = 1'b1; in = 6'h33;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    check("pre_rst_out", 32'(out), 32'h33);
    async_reset("rst_lookup");
    load_full(1'b0, "reload2");
    look(6'h3f, 1'b1, 6'h2a);

    // Duplicate address -> sticky error
    do_clear();
    for (int unsigned x = 0; x < 10; x++) wr(W'(x), W'(x));
    wr(6'h05, 6'h20);
    check("dupaddr_error", 32'(error), 32'd1);
    check("dupaddr_ready", 32'(ready), 32'd0);
    wr(6'h0a, 6'h0a);
    look(6'h01, 1'b0, '0);
    check("err_lookup_out_valid", 32'(out_valid), 32'd0);
    check("err_sticky", 32'(error), 32'd1);

    // Duplicate data -> error; clear leaves ERROR
    do_clear();
    check("clr_from_err", 32'(error), 32'd0);
    for (int unsigned x = 0; x < 10; x++) wr(W'(x), W'(x));
    check("pre_dupdata_error", 32'(error), 32'd0);
    wr(6'h30, 6'h03);
    check("dupdata_error", 32'(error), 32'd1);
    check("dupdata_ready", 32'(ready), 32'd0);

    for (int unsigned i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/odo_sbox_inv_loader.md
ODO_SBOX_INV_LOADER -- requirements
Module: odo_sbox_inv_loader

Interface
REQ-001 The block SHALL have parameter W, default 6, meaning S-box symbol width; table depth is 2^W.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port clear  input  1  synchronous return to LOAD state, discarding the loaded table.
REQ-005 The block SHALL have port wr_en  input  1  forward-table entry write strobe.
REQ-006 The block SHALL have port wr_addr  input  W  forward-table index x.
REQ-007 The block SHALL have port wr_data  input  W  forward-table value S(x).
REQ-008 The block SHALL have port in_valid  input  1  inverse lookup request strobe.
REQ-009 The block SHALL have port in  input  W  lookup value y.
REQ-010 The block SHALL have port out  output  W  registered inverse result S^-1(y).
REQ-011 The block SHALL have port out_valid  output  1  out holds a valid result this cycle.
REQ-012 The block SHALL have port ready  output  1  complete bijective table loaded; lookups accepted.
REQ-013 The block SHALL have port error  output  1  sticky: forward table is not a permutation.

Function
REQ-014 The block SHALL implement states LOAD, READY, ERROR; ready = (state==READY), error = (state==ERROR).
REQ-015 In LOAD, an accepted write SHALL store inv[wr_data] <= wr_addr, set addr_seen[wr_addr] and data_seen[wr_data], and increment a (W+1)-bit count.
REQ-016 In LOAD, a write whose wr_addr or wr_data is already marked seen SHALL move the block to ERROR without modifying inv, seen vectors or count.
REQ-017 When a non-duplicate write brings count to 2^W, the block SHALL enter READY on that same clock edge (ready high the following cycle).
REQ-018 Writes in READY or ERROR SHALL be ignored entirely.
REQ-019 In READY, in_valid SHALL produce out = inv[in] and out_valid = 1 exactly one cycle later; one lookup per cycle, fully pipelined, no backpressure.
REQ-020 in_valid in LOAD or ERROR SHALL be ignored: out_valid = 0 the next cycle and out holds its previous value.
REQ-021 When in_valid is low, out_valid SHALL be 0 the next cycle and out SHALL hold its previous value.
REQ-022 clear SHALL, on the clock edge, set state LOAD, count 0, all seen bits 0, out_valid 0; inv contents need not be cleared.
REQ-023 clear SHALL take priority over a simultaneous wr_en (write discarded) and over in_valid (out_valid 0 next cycle).
REQ-024 A lookup accepted on the cycle before clear SHALL still produce its out_valid pulse; the clear-edge lookup SHALL not.
REQ-025 The inverse table SHALL be inferable as a 2^W x W synchronous RAM (one write port, one registered read port); seen vectors are flops.

Reset
REQ-026 On rst_n low, the block SHALL asynchronously force state LOAD, count 0, all seen bits 0, out 0, out_valid 0, ready 0, error 0.
REQ-027 Reset deassertion SHALL be used synchronously to clk; first write accepted on the first rising edge with rst_n high.
REQ-028 Reset asserted mid-load or mid-lookup SHALL discard all progress; in-flight out_valid SHALL drop immediately.

Verification
REQ-029 Identity load (x -> x, x = 0..63, one per cycle) -> ready rises the cycle after write 63; lookup in=0x2a -> out=0x2a, out_valid 1 one cycle later.
REQ-030 Load S(0)=0x2d and remaining entries as a permutation, then lookup in=0x2d -> out=0x00; back-to-back lookups 0x2d,0x00,0x3f -> three consecutive out_valid cycles with correct inverses.
REQ-031 Load 10 entries then write wr_addr=0x05 twice (or wr_data=0x11 twice) -> error=1 next cycle, ready stays 0, further writes and lookups ignored (out_valid 0).
REQ-032 In READY assert clear together with wr_en and in_valid -> next cycle ready=0, error=0, out_valid=0; count restarts at 0 and a full reload reaches READY again.
REQ-033 Drop rst_n asynchronously mid-load (after 40 writes) and while out_valid=1 -> outputs zero without waiting for a clock edge; full 64-entry reload then reaches READY.
REQ-034 Lookup in LOAD with 63 entries written -> out_valid 0; write the 64th entry -> ready next cycle and lookups succeed.
